// File: rtl/mem_lsu_stage_if.sv
// Request/response bus between the MEM-stage load/store unit and a
// variable-latency data memory.
interface mem_lsu_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [XLEN/8-1:0]   req_be;
  logic [XLEN-1:0]     req_wdata;
  logic                rvalid;
  logic [XLEN-1:0]     rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rvalid, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu_stage.sv
// MEM-stage load/store unit: aligns and issues one data-memory access per
// load/store over a valid/ready bus, extends load data and flags faults.
module mem_lsu_stage #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  output logic              stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_load_data,
  output logic              out_exc,
  output logic [1:0]        out_exc_cause,
  mem_lsu_stage_if.master   mem
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [2:0]        off_q;
  logic [XLEN-1:0]   load_q;
  logic              exc_q;
  logic [1:0]        cause_q;

  logic [2:0]  off;
  logic [7:0]  size_mask;
  logic [63:0] sd64;
  logic [63:0] sd_masked;
  logic        misaligned;
  logic        unsupported;
  logic [1:0]  dec_cause;
  logic [7:0]  be_full;
  logic [63:0] wdata_full;
  logic [63:0] rshift;
  logic [63:0] load_ext;
  logic        timeout;

  // Offset is kept 3 bits wide so the doubleword check is uniform at XLEN=32.
  assign off        = 3'(in_addr[OFF_W-1:0]);
  assign sd64       = 64'(in_store_data);
  assign be_full    = size_mask << off;
  assign wdata_full = sd_masked << {off, 3'b000};

  always_comb begin
    size_mask   = 8'h01;
    sd_masked   = '0;
    misaligned  = 1'b0;
    unsupported = 1'b0;
    dec_cause   = 2'd0;
    case (in_funct3[1:0])
      2'd0: begin size_mask = 8'h01; sd_masked = {56'h0, sd64[7:0]};  misaligned = 1'b0;      end
      2'd1: begin size_mask = 8'h03; sd_masked = {48'h0, sd64[15:0]}; misaligned = off[0];    end
      2'd2: begin size_mask = 8'h0F; sd_masked = {32'h0, sd64[31:0]}; misaligned = |off[1:0]; end
      default: begin size_mask = 8'hFF; sd_masked = sd64;             misaligned = |off;      end
    endcase
    if (in_is_store)
      unsupported = (XLEN == 32) ? (in_funct3 > 3'd2) : (in_funct3 > 3'd3);
    else
      unsupported = (in_funct3 == 3'b111) ||
                    ((XLEN == 32) && ((in_funct3 == 3'b011) || (in_funct3 == 3'b110)));
    if (unsupported)
      dec_cause = 2'd3;
    else if (misaligned)
      dec_cause = in_is_store ? 2'd2 : 2'd1;
  end

  assign rshift = 64'(mem.rdata) >> {off_q, 3'b000};

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      3'b000:  load_ext = {{56{rshift[7]}},  rshift[7:0]};
      3'b001:  load_ext = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  load_ext = {{32{rshift[31]}}, rshift[31:0]};
      3'b011:  load_ext = rshift;
      3'b100:  load_ext = {56'h0, rshift[7:0]};
      3'b101:  load_ext = {48'h0, rshift[15:0]};
      3'b110:  load_ext = {32'h0, rshift[31:0]};
      default: load_ext = '0;
    endcase
  end

  // A response in the last allowed WAIT cycle still completes normally.
  assign timeout = ((state == REQ) || ((state == WAIT) && !mem.rvalid)) && (cnt == CNT_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = (dec_cause != 2'd0) ? DONE : REQ;
      REQ: begin
        if (timeout)            state_n = DONE;
        else if (mem.req_ready) state_n = WAIT;
      end
      WAIT: if (mem.rvalid || timeout) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      load_q   <= '0;
      exc_q    <= 1'b0;
      cause_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= ((state == REQ) || (state == WAIT)) ? cnt + CNT_W'(1) : '0;
      load_q  <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_cause != 2'd0) begin
              exc_q   <= 1'b1;
              cause_q <= dec_cause;
            end else begin
              addr_q   <= in_addr & ~ADDR_W'(NB - 1);
              be_q     <= be_full[NB-1:0];
              wdata_q  <= wdata_full[XLEN-1:0];
              we_q     <= in_is_store;
              funct3_q <= in_funct3;
              off_q    <= off;
            end
          end
        end
        REQ, WAIT: begin
          if (timeout) begin
            exc_q   <= 1'b1;
            cause_q <= 2'd3;
          end else if ((state == WAIT) && mem.rvalid && !we_q) begin
            load_q <= load_ext[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign stall         = in_valid & ~out_valid;
  assign out_valid     = (state == DONE);
  assign out_load_data = load_q;
  assign out_exc       = exc_q;
  assign out_exc_cause = cause_q;

  assign mem.req_valid = (state == REQ);
  assign mem.req_we    = we_q;
  assign mem.req_addr  = addr_q;
  assign mem.req_be    = be_q;
  assign mem.req_wdata = wdata_q;
endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: one XLEN=32 and one XLEN=64 instance, directed
// cases followed by random loads/stores against a byte-level reference model.
module tb_mem_lsu_stage;
  localparam int T32 = 8;
  localparam int T64 = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel64 = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [63:0] in_store_data = '0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        stall32, ov32, exc32;
  logic [1:0]  cause32;
  logic [31:0] ld32;
  logic        stall64, ov64, exc64;
  logic [1:0]  cause64;
  logic [63:0] ld64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_lsu_stage_if #(.XLEN(32), .ADDR_W(32)) bus32 ();
  mem_lsu_stage_if #(.XLEN(64), .ADDR_W(32)) bus64 ();

  assign bus32.req_ready = mem_ready & ~sel64;
  assign bus32.rvalid    = mem_rvalid & ~sel64;
  assign bus32.rdata     = mem_rdata[31:0];
  assign bus64.req_ready = mem_ready & sel64;
  assign bus64.rvalid    = mem_rvalid & sel64;
  assign bus64.rdata     = mem_rdata;

  mem_lsu_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(T32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & ~sel64), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data[31:0]),
    .stall(stall32), .out_valid(ov32), .out_load_data(ld32), .out_exc(exc32),
    .out_exc_cause(cause32), .mem(bus32.master)
  );

  mem_lsu_stage #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(T64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & sel64), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
    .stall(stall64), .out_valid(ov64), .out_load_data(ld64), .out_exc(exc64),
    .out_exc_cause(cause64), .mem(bus64.master)
  );

  logic        obs_stall, obs_ov, obs_exc, obs_req_valid, obs_req_we;
  logic [1:0]  obs_cause;
  logic [63:0] obs_load, obs_wdata;
  logic [7:0]  obs_be;
  logic [31:0] obs_addr;

  assign obs_stall     = sel64 ? stall64 : stall32;
  assign obs_ov        = sel64 ? ov64 : ov32;
  assign obs_exc       = sel64 ? exc64 : exc32;
  assign obs_cause     = sel64 ? cause64 : cause32;
  assign obs_load      = sel64 ? ld64 : {32'h0, ld32};
  assign obs_req_valid = sel64 ? bus64.req_valid : bus32.req_valid;
  assign obs_req_we    = sel64 ? bus64.req_we : bus32.req_we;
  assign obs_addr      = sel64 ? bus64.req_addr : bus32.req_addr;
  assign obs_be        = sel64 ? bus64.req_be : {4'h0, bus32.req_be};
  assign obs_wdata     = sel64 ? bus64.req_wdata : {32'h0, bus32.req_wdata};

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".stall"},     obs_stall, 0);
    check_output({tag, ".out_valid"}, obs_ov, 0);
    check_output({tag, ".load"},      obs_load, 0);
    check_output({tag, ".exc"},       obs_exc, 0);
    check_output({tag, ".cause"},     obs_cause, 0);
    check_output({tag, ".req_valid"}, obs_req_valid, 0);
    check_output({tag, ".req_we"},    obs_req_we, 0);
    check_output({tag, ".req_addr"},  obs_addr, 0);
    check_output({tag, ".req_be"},    obs_be, 0);
    check_output({tag, ".req_wdata"}, obs_wdata, 0);
  endtask

  // Byte-lane view of an access: legality, enables, store lanes, load result.
  function automatic void ref_model(input bit x64, input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] sd, input logic [63:0] rd,
      output logic [1:0] cause, output logic [31:0] eaddr, output logic [7:0] be,
      output logic [63:0] wd, output logic [63:0] ld);
    int nb, size, off;
    bit ok_f3;
    nb   = x64 ? 8 : 4;
    size = 1 << f3[1:0];
    off  = int'(a[2:0]) % nb;
    if (st) ok_f3 = (f3 <= (x64 ? 3'd3 : 3'd2));
    else    ok_f3 = (f3 != 3'd7) && (x64 || ((f3 != 3'd3) && (f3 != 3'd6)));
    if (!ok_f3)             cause = 2'd3;
    else if (off % size != 0) cause = st ? 2'd2 : 2'd1;
    else                    cause = 2'd0;
    eaddr = a - 32'(off);
    be = '0; wd = '0; ld = '0;
    if (cause == 2'd0) begin
      for (int i = 0; i < size; i++) begin
        be[off+i] = 1'b1;
        wd[8*(off+i) +: 8] = sd[8*i +: 8];
        ld[8*i +: 8] = rd[8*(off+i) +: 8];
      end
      if (!st && !f3[2] && size < 8 && ld[8*size-1])
        for (int i = size; i < 8; i++) ld[8*i +: 8] = 8'hFF;
      if (!x64) ld[63:32] = 32'h0;
      if (st) ld = '0;
    end
  endfunction

  // Runs one instruction from in_valid (cycle 0) to the cycle after out_valid.
  task automatic apply_stimulus(input bit x64, input bit st, input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] sd, input logic [63:0] rd,
      input int rdy_dly, input int rsp_dly);
    logic [1:0]  e_cause;
    logic [31:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wd, e_ld, rd_eff;
    int tmo, hs_c, rv_c, done_c, req_last;
    tmo    = x64 ? T64 : T32;
    rd_eff = x64 ? rd : {32'h0, rd[31:0]};
    ref_model(x64, st, f3, a, sd, rd_eff, e_cause, e_addr, e_be, e_wd, e_ld);
    hs_c = 1 + rdy_dly;
    rv_c = hs_c + 1 + rsp_dly;
    if (e_cause != 2'd0) begin
      done_c = 1; req_last = 0; e_ld = '0;
    end else if (rv_c <= tmo) begin
      done_c = rv_c + 1; req_last = hs_c;
    end else begin
      done_c = tmo + 1; req_last = (hs_c < tmo) ? hs_c : tmo;
      e_cause = 2'd3; e_ld = '0;
    end
    sel64 = x64; in_valid = 1'b1; in_is_store = st; in_funct3 = f3;
    in_addr = a; in_store_data = sd;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      check_output("out_valid", obs_ov, 64'(c == done_c));
      check_output("stall", obs_stall, 64'(c != done_c));
      check_output("req_valid", obs_req_valid, 64'(c >= 1 && c <= req_last));
      if (c >= 1 && c <= req_last) begin
        check_output("req_addr", obs_addr, e_addr);
        check_output("req_be", obs_be, e_be);
        check_output("req_wdata", obs_wdata, st ? e_wd : obs_wdata);
        check_output("req_we", obs_req_we, st);
      end
      if (c == done_c) begin
        check_output("out_exc", obs_exc, 64'(e_cause != 2'd0));
        check_output("out_exc_cause", obs_cause, e_cause);
        check_output("out_load_data", obs_load, e_ld);
      end
      mem_ready  = (c == hs_c) && (c <= req_last);
      mem_rvalid = (c == rv_c) || (c >= 1 && c <= req_last && $urandom_range(0, 3) == 0);
      mem_rdata  = (c == rv_c) ? rd : {$urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    bit          rx64, rst;
    logic [2:0]  rf3;
    logic [31:0] ra;

    $display("[TB] start");
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel64 = 1'b0; #1 check_all_zero("reset32");
    sel64 = 1'b1; #1 check_all_zero("reset64");
    @(posedge clk); #1 reset_n = 1'b1;

    apply_stimulus(0, 0, 3'b000, 32'h103, 64'h0, 64'h8000_0000, 0, 1);
    apply_stimulus(0, 1, 3'b001, 32'h202, 64'h1234_ABCD, 64'h0, 3, 0);
    apply_stimulus(0, 0, 3'b010, 32'h101, 64'h0, 64'h0, 0, 0);
    apply_stimulus(0, 1, 3'b010, 32'h106, 64'h5555_AAAA, 64'h0, 0, 0);
    apply_stimulus(0, 0, 3'b011, 32'h100, 64'h0, 64'h0, 0, 0);
    apply_stimulus(0, 0, 3'b111, 32'h100, 64'h0, 64'h0, 0, 0);
    apply_stimulus(0, 1, 3'b011, 32'h100, 64'h0, 64'h0, 0, 0);
    apply_stimulus(0, 0, 3'b101, 32'h302, 64'h0, 64'h8001_0000, 1, 2);

    apply_stimulus(0, 0, 3'b010, 32'h40, 64'h0, 64'h0, 0, 1000);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    @(negedge clk);
    check_output("late_rvalid.out_valid", obs_ov, 0);
    check_output("late_rvalid.req_valid", obs_req_valid, 0);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    check_output("late_rvalid.out_valid2", obs_ov, 0);
    @(posedge clk); #1;
    apply_stimulus(0, 0, 3'b010, 32'h44, 64'h0, 64'h8765_4321, 0, 0);

    apply_stimulus(1, 0, 3'b110, 32'h1004, 64'h0, 64'hF000_0000_0000_0000, 0, 0);
    apply_stimulus(1, 0, 3'b011, 32'h1004, 64'h0, 64'h0, 0, 0);
    apply_stimulus(1, 1, 3'b011, 32'h1008, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0);
    apply_stimulus(1, 0, 3'b011, 32'h1010, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 2);
    apply_stimulus(1, 1, 3'b100, 32'h1010, 64'h0, 64'h0, 0, 0);

    // Abort an access from WAIT, then show a stray response is ignored.
    sel64 = 1'b0; in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst_seq.req_valid", obs_req_valid, 1);
    mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check_output("rst_seq.wait_req_valid", obs_req_valid, 0);
    check_output("rst_seq.wait_out_valid", obs_ov, 0);
    @(posedge clk); #1 reset_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF;
    @(negedge clk);
    check_all_zero("after_reset");
    @(posedge clk); #1 mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_output("post_reset.out_valid", obs_ov, 0);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 150; n++) begin
      rx64 = 1'($urandom_range(0, 1));
      rst  = 1'($urandom_range(0, 1));
      rf3  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      if ($urandom_range(0, 1) == 1) ra[2:0] = 3'b000;
      apply_stimulus(rx64, rst, rf3, ra, {$urandom, $urandom}, {$urandom, $urandom},
                     $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
